// File: rtl/mac_vector_unit.sv
// mac_vector_unit: LANES-wide signed S5.10 x S1.6 multiply, adder-tree reduce, saturating accumulate over cfg_len beats.
// Latency: final beat accepted at edge k -> result valid after edge k+2; one beat per cycle while accumulating.
// Backpressure: in_ready low in DRAIN/HOLD; the result is held stable in HOLD until out_valid && out_ready.
module mac_vector_unit #(
  parameter int LANES        = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DATA_FRAC    = 10,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WEIGHT_FRAC  = 6,
  parameter int ACCUM_WIDTH  = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int OUT_FRAC     = 10,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          abort,
  input  logic [LEN_WIDTH-1:0]          cfg_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   data_in,
  input  logic [LANES*WEIGHT_WIDTH-1:0] weight_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [ACCUM_WIDTH-1:0]        out_accum,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int LW    = $clog2(LANES);
  localparam int SW    = PW + LW;
  localparam int XW    = ACCUM_WIDTH + 1;
  localparam int SHIFT = DATA_FRAC + WEIGHT_FRAC - OUT_FRAC;

  // Clamp bounds and rounding increment, all sign-extended to the XW-bit working width.
  localparam logic signed [XW-1:0] ACC_MAX = {2'b00, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_MIN = {2'b11, {(ACCUM_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] OUT_MAX = {{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] OUT_MIN = {{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0] RND_INC = XW'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  state_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [LEN_WIDTH-1:0]    cnt_inc;
  logic                    drain_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    accept;

  logic signed [PW-1:0]          prod_d [LANES];
  logic signed [PW-1:0]          prod_q [LANES];
  logic                          p_vld_q;
  logic                          p_first_q;
  logic signed [SW-1:0]          tree_sum;
  logic signed [XW-1:0]          acc_sum;
  logic signed [ACCUM_WIDTH-1:0] acc_q;
  logic signed [ACCUM_WIDTH-1:0] acc_d;
  logic                          sat_q;
  logic                          sat_d;

  logic signed [XW-1:0]   rnd_sum;
  logic signed [XW-1:0]   rnd_shift;
  logic [OUT_WIDTH-1:0]   rnd_out;
  logic                   rnd_clamp;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic [ACCUM_WIDTH-1:0] out_accum_q;
  logic                   out_sat_q;

  assign accept  = in_valid && in_ready_q;
  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  // Beat sequencing: count accepted beats, let the two pipeline stages empty, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            len_q <= cfg_len;
            cnt_q <= LEN_WIDTH'(1);
            // A length of 0 or 1 is a single-beat dot product.
            if (cfg_len <= LEN_WIDTH'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          drain_q <= ~drain_q;
          if (drain_q) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-lane signed products of the beat on the input.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PW'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]))
                * PW'($signed(weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    end
  end

  // Lane reduction; the LW guard bits keep the sum exact.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SW'(prod_q[i]);
    end
  end

  // Accumulate with clamp; a first beat reloads and clears the sticky flag.
  always_comb begin
    acc_sum = XW'(acc_q) + XW'(tree_sum);
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (p_vld_q) begin
      if (p_first_q) begin
        acc_d = ACCUM_WIDTH'(tree_sum);
        sat_d = 1'b0;
      end else if (acc_sum > ACC_MAX) begin
        acc_d = ACC_MAX[ACCUM_WIDTH-1:0];
        sat_d = 1'b1;
      end else if (acc_sum < ACC_MIN) begin
        acc_d = ACC_MIN[ACCUM_WIDTH-1:0];
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACCUM_WIDTH-1:0];
      end
    end
  end

  // Product and accumulator pipeline registers; abort discards any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (abort) begin
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      p_vld_q   <= accept;
      p_first_q <= accept && (state_q == IDLE);
      if (accept) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  // Round half up by adding half an LSB before the arithmetic shift, then clamp to the output range.
  always_comb begin
    rnd_sum   = XW'(acc_q) + RND_INC;
    rnd_shift = rnd_sum >>> SHIFT;
    rnd_out   = rnd_shift[OUT_WIDTH-1:0];
    rnd_clamp = 1'b0;
    if (rnd_shift > OUT_MAX) begin
      rnd_out   = OUT_MAX[OUT_WIDTH-1:0];
      rnd_clamp = 1'b1;
    end else if (rnd_shift < OUT_MIN) begin
      rnd_out   = OUT_MIN[OUT_WIDTH-1:0];
      rnd_clamp = 1'b1;
    end
  end

  // Result registers, captured on the last DRAIN cycle and held through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_accum_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (abort) begin
      out_data_q  <= '0;
      out_accum_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (state_q == DRAIN && drain_q) begin
      out_data_q  <= rnd_out;
      out_accum_q <= acc_q;
      out_sat_q   <= sat_q | rnd_clamp;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_accum = out_accum_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_vector_unit.sv
// tb_mac_vector_unit: directed dot products against a real-arithmetic reference model of the MAC.
// Latency, handshake, abort and reset behaviour are checked at fixed cycle offsets from the final beat.
// The consumer side stalls out_ready on demand to exercise result holding.
module tb_mac_vector_unit;
  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int WW    = 8;
  localparam int AW    = 32;
  localparam int SHIFT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_in = '0;
  logic [31:0] weight_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [31:0] out_accum;
  logic        out_sat;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] bd [256];
  logic [31:0] bw [256];

  typedef struct {
    longint acc;
    longint od;
    bit     sat;
  } res_t;

  res_t exp_q[$];

  mac_vector_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_accum (out_accum),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired or unexpected event", name);
  endtask

  // Reference: exact integer dot products, clamped running sum, real-valued round-half-up.
  function automatic res_t model(input int n);
    res_t   r;
    longint s;
    longint mx;
    longint mn;
    longint o;
    real    scaled;
    mx = (64'sd1 <<< (AW - 1)) - 1;
    mn = -(64'sd1 <<< (AW - 1));
    r.acc = 0;
    r.sat = 1'b0;
    for (int b = 0; b < n; b++) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        s += longint'($signed(bd[b][l*DW +: DW])) * longint'($signed(bw[b][l*WW +: WW]));
      end
      r.acc = (b == 0) ? s : r.acc + s;
      if (r.acc > mx) begin r.acc = mx; r.sat = 1'b1; end
      if (r.acc < mn) begin r.acc = mn; r.sat = 1'b1; end
    end
    scaled = real'(r.acc) / real'(64'sd1 <<< SHIFT);
    o = longint'($floor(scaled + 0.5));
    if (o > 32767)  begin o = 32767;  r.sat = 1'b1; end
    if (o < -32768) begin o = -32768; r.sat = 1'b1; end
    r.od = o;
    return r;
  endfunction

  task automatic fill(input int n, input logic [63:0] d, input logic [31:0] w);
    for (int i = 0; i < n; i++) begin
      bd[i] = d;
      bw[i] = w;
    end
  endtask

  // Present one beat and wait (bounded) for it to be taken; returns at posedge+1.
  task automatic send_beat(input logic [63:0] d, input logic [31:0] w, output bit ok);
    int guard;
    guard     = 0;
    ok        = 1'b0;
    data_in   = d;
    weight_in = w;
    in_valid  = 1'b1;
    while (!ok && guard < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) fail_now("beat_accept");
  endtask

  // Full dot product: beats, latency checks, optional literal result, stalled consumer, handshake.
  task automatic run_dot(input int len, input int gap, input int hold, input bit lit,
                         input longint l_acc, input longint l_od, input bit l_sat);
    int n;
    bit ok;
    n = (len == 0) ? 1 : len;
    cfg_len = 8'(len);
    for (int b = 0; b < n; b++) begin
      send_beat(bd[b], bw[b], ok);
      if (!ok) return;
      if (b == 0) check("busy_after_first", busy, 1);
      if (gap != 0 && b != n - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    exp_q.push_back(model(n));
    @(negedge clk); check("in_ready_after_k", in_ready, 0);
    @(negedge clk); check("out_valid_after_k1", out_valid, 0);
    @(negedge clk); check("out_valid_after_k2", out_valid, 1);
    if (lit) begin
      check("lit_accum", longint'($signed(out_accum)), l_acc);
      check("lit_data", longint'($signed(out_data)), l_od);
      check("lit_sat", out_sat, l_sat);
    end
    repeat (hold) begin
      @(negedge clk);
      check("in_ready_hold", in_ready, 0);
      check("out_valid_hold", out_valid, 1);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  // Every cycle a result is presented it must equal the oldest model result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_out_valid");
      end else begin
        check("model_accum", longint'($signed(out_accum)), exp_q[0].acc);
        check("model_data", longint'($signed(out_data)), exp_q[0].od);
        check("model_sat", out_sat, exp_q[0].sat);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit ok;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_accum", out_accum, 0);
    check("rst_out_sat", out_sat, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_release", in_ready, 1);

    // Basic sum: 4 lanes x 1.0 x 1.0, two beats
    fill(2, 64'h0400_0400_0400_0400, 32'h4040_4040);
    run_dot(2, 0, 0, 1'b1, 524288, 8192, 1'b0);

    // Sign: -1.0 x 0.5
    fill(1, 64'hFC00_FC00_FC00_FC00, 32'h2020_2020);
    run_dot(1, 0, 0, 1'b1, -131072, -2048, 1'b0);

    // Rounding at the half-LSB boundary
    fill(1, 64'h0000_0000_0000_0001, 32'h0000_0020);
    run_dot(1, 0, 0, 1'b1, 32, 1, 1'b0);
    fill(1, 64'h0000_0000_0000_0001, 32'h0000_001F);
    run_dot(1, 0, 0, 1'b1, 31, 0, 1'b0);
    fill(1, 64'h0000_0000_0000_FFFF, 32'h0000_0020);
    run_dot(1, 0, 0, 1'b1, -32, 0, 1'b0);

    // cfg_len of 0 behaves as a single beat
    fill(1, 64'h0400_0400_0400_0400, 32'h4040_4040);
    run_dot(0, 0, 0, 1'b1, 262144, 4096, 1'b0);

    // Output saturation, positive and negative
    fill(1, 64'h7FFF_7FFF_7FFF_7FFF, 32'h7F7F_7F7F);
    run_dot(1, 0, 0, 1'b1, 16645636, 32767, 1'b1);
    fill(1, 64'h8000_8000_8000_8000, 32'h7F7F_7F7F);
    run_dot(1, 0, 0, 1'b1, -16646144, -32768, 1'b1);

    // Mixed-sign beats with input gaps and a 5-cycle stalled consumer
    bd[0] = 64'h0800_F000_0123_FFFE; bw[0] = 32'h40C0_0580;
    bd[1] = 64'h8000_7FFF_0001_0400; bw[1] = 32'h7F80_FF10;
    bd[2] = 64'h1234_5678_9ABC_DEF0; bw[2] = 32'h0AB3_7CE1;
    run_dot(3, 1, 5, 1'b0, 0, 0, 1'b0);

    // Accumulator saturation over 255 full-scale beats
    fill(255, 64'h7FFF_7FFF_7FFF_7FFF, 32'h7F7F_7F7F);
    run_dot(255, 0, 0, 1'b1, 2147483647, 32767, 1'b1);

    // Abort on beat 3 of 5 flushes everything
    cfg_len = 8'd5;
    send_beat(64'h7FFF_7FFF_7FFF_7FFF, 32'h7F7F_7F7F, ok);
    send_beat(64'h7FFF_7FFF_7FFF_7FFF, 32'h7F7F_7F7F, ok);
    data_in   = 64'h1111_2222_3333_4444;
    weight_in = 32'h1122_3344;
    in_valid  = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_accum", out_accum, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_sat", out_sat, 0);
    fill(3, 64'h0200_0200_0200_0200, 32'h4040_4040);
    run_dot(3, 0, 0, 1'b1, 393216, 6144, 1'b0);

    // Reset in the middle of ACCUM
    fill(4, 64'h0400_0400_0400_0400, 32'h4040_4040);
    cfg_len = 8'd4;
    send_beat(bd[0], bw[0], ok);
    send_beat(bd[1], bw[1], ok);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_accum", out_accum, 0);
    check("midrst_out_sat", out_sat, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_after", in_ready, 1);
    fill(2, 64'h0400_0400_0400_0400, 32'h4040_4040);
    run_dot(2, 0, 0, 1'b1, 524288, 8192, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("results_all_consumed", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
